ssd_display_driver: RTL

//  Consumes the 13-bit value the processor top routes to the seven-segment display.

---
 rtl/ssd_pkg.sv | 62 ++++++
 rtl/ssd_bcd_seq.sv | 76 +++++++
 rtl/ssd_display_driver.sv | 94 +++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver:
// conversion FSM states, active-low segment/anode codes and small helpers.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BIN_W = 13;
    localparam int NDIG  = 4;
    localparam int BCD_W = 4 * NDIG;

    // cnt value on the 13th and final shift
    localparam logic [3:0] LAST_SHIFT = 4'd12;

    // Segment codes {a,b,c,d,e,f,g}, active low
    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Digit enables, active low
    localparam logic [3:0] ANODE_ONES  = 4'b1110;
    localparam logic [3:0] ANODE_TENS  = 4'b1101;
    localparam logic [3:0] ANODE_HUND  = 4'b1011;
    localparam logic [3:0] ANODE_THOUS = 4'b0111;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Double-dabble correction applied to each nibble before a shift
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/ssd_bcd_seq.sv
// Sequential double-dabble converter: captures a 13-bit value, shifts it into
// four BCD nibbles over 13 cycles and publishes all digits at once.
module ssd_bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] num_in,
    output logic [BCD_W-1:0] digits,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] digits_q, digits_d;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = dd_adjust(bcd_q[gi*4 +: 4]);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                bin_d   = num_in;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Only a completed conversion ever reaches the display
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
        end
    end

    assign digits = digits_q;
    assign busy   = (state_q == SHIFT);

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode display driver: BCD conversion of num_in plus a
// refresh-counter digit scan with optional leading-zero blanking.
module ssd_display_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] num_in,
    output logic             busy,
    output logic [3:0]       Anode,
    output logic [6:0]       LED_out
);

    logic [BCD_W-1:0]        digits;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [1:0]              sel;
    logic [NDIG-1:0]         blank_vec;
    logic [3:0]              nib;
    logic                    blank;
    logic [3:0]              anode_q, anode_d;
    logic [6:0]              led_q, led_d;

    ssd_bcd_seq u_bcd_seq (
        .clk    (clk),
        .reset  (reset),
        .num_in (num_in),
        .digits (digits),
        .busy   (busy)
    );

    // A digit is blanked when it and every more-significant digit are zero;
    // the ones digit is never blanked so a value of 0 still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_blank
            if (BLANK_LZ && (gi != 0)) begin : g_lz
                assign blank_vec[gi] = (digits[BCD_W-1:gi*4] == '0);
            end else begin : g_lit
                assign blank_vec[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        refresh_d = refresh_q + REFRESH_BITS'(1);
        sel       = refresh_q[REFRESH_BITS-1 -: 2];
        anode_d   = ANODE_OFF;
        nib       = 4'd0;
        blank     = 1'b0;
        case (sel)
            2'd0: begin
                anode_d = ANODE_ONES;
                nib     = digits[3:0];
                blank   = blank_vec[0];
            end
            2'd1: begin
                anode_d = ANODE_TENS;
                nib     = digits[7:4];
                blank   = blank_vec[1];
            end
            2'd2: begin
                anode_d = ANODE_HUND;
                nib     = digits[11:8];
                blank   = blank_vec[2];
            end
            default: begin
                anode_d = ANODE_THOUS;
                nib     = digits[15:12];
                blank   = blank_vec[3];
            end
        endcase
        led_d = blank ? SEG_OFF : seg_encode(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            anode_q   <= ANODE_OFF;
            led_q     <= SEG_OFF;
        end else begin
            refresh_q <= refresh_d;
            anode_q   <= anode_d;
            led_q     <= led_d;
        end
    end

    assign Anode   = anode_q;
    assign LED_out = led_q;

endmodule
